register_pair_sequencer: RTL and testbench

- Sits directly upstream of the 256x8 register RAM: the single owner of that RAM's write_en, address and data_in; consumes its data_out.
- Converts CPU-side register requests (byte or 16-bit pair, per interrupt level) into byte-wide RAM cycles and returns read data with a response pulse.
- Address map: RAM address = {level[3:0], byte_index[3:0]}.
  - 16 levels x 16 bytes.
  - Pair w = bytes 2w (high) and 2w+1 (low), big-endian.
- Hardware scrub zeroes all 256 bytes after reset or on request, since RAM initial contents exist only in simulation.

---
 rtl/register_pair_sequencer_if.sv | 40 ++++
 rtl/register_pair_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_register_pair_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_pair_sequencer_if.sv
// CPU-side request/response bundle for the register pair sequencer.
// master = CPU side, slave = sequencer.
interface register_pair_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [3:0]  req_level;
  logic [3:0]  req_index;
  logic [15:0] req_wdata;
  logic        clear_start;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_write,
    output req_word,
    output req_level,
    output req_index,
    output req_wdata,
    output clear_start,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_word,
    input  req_level,
    input  req_index,
    input  req_wdata,
    input  clear_start,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/register_pair_sequencer.sv
// Byte/pair register access sequencer and scrubber
// in front of the 256x8 register RAM.
module register_pair_sequencer #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  register_pair_sequencer_if.slave bus,
  output logic       ram_write_en,
  output logic [7:0] ram_address,
  output logic [7:0] ram_data_in,
  input  logic [7:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_HI     = 3'd2,
    S_LO     = 3'd3,
    S_CAP_HI = 3'd4,
    S_CAP_LO = 3'd5
  } state_t;

  localparam state_t RST_STATE =
    CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t state_q, state_d;

  logic [3:0]  lvl_q, lvl_d;
  logic [2:0]  pair_q, pair_d;
  logic        wr_q, wr_d;
  logic        wd_q, wd_d;
  logic [7:0]  wlo_q, wlo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rv_q, rv_d;
  logic [15:0] rd_q, rd_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  din_q, din_d;

  logic idle;
  logic accept;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle & bus.req_valid
                & ~bus.clear_start;

  assign bus.req_ready = idle;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rd_q;
  assign ram_write_en  = we_q;
  assign ram_address   = addr_q;
  assign ram_data_in   = din_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= RST_STATE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLEAR: begin
        if (cnt_q == 8'hFF) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.clear_start)    state_d = S_CLEAR;
        else if (bus.req_valid) state_d = S_HI;
      end
      S_HI: begin
        if (wd_q)      state_d = S_LO;
        else if (wr_q) state_d = S_IDLE;
        else           state_d = S_CAP_LO;
      end
      S_LO: begin
        state_d = wr_q ? S_IDLE : S_CAP_LO;
      end
      S_CAP_LO: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lvl_d  = lvl_q;
    pair_d = pair_q;
    wr_d   = wr_q;
    wd_d   = wd_q;
    wlo_d  = wlo_q;
    hi_d   = hi_q;
    cnt_d  = cnt_q;
    rv_d   = 1'b0;
    rd_d   = rd_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    unique case (state_q)
      S_CLEAR: begin
        we_d   = 1'b1;
        din_d  = 8'h00;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 8'd1;
      end
      S_IDLE: begin
        if (bus.clear_start) begin
          cnt_d = 8'h00;
        end else if (accept) begin
          lvl_d  = bus.req_level;
          pair_d = bus.req_index[3:1];
          wr_d   = bus.req_write;
          wd_d   = bus.req_word;
          wlo_d  = bus.req_wdata[7:0];
          we_d   = bus.req_write;
          unique case (1'b1)
            bus.req_word: begin
              addr_d = {bus.req_level,
                        bus.req_index[3:1],
                        1'b0};
              din_d  = bus.req_wdata[15:8];
            end
            default: begin
              addr_d = {bus.req_level,
                        bus.req_index};
              din_d  = bus.req_wdata[7:0];
            end
          endcase
        end
      end
      S_HI: begin
        if (wd_q) begin
          addr_d = {lvl_q, pair_q, 1'b1};
          din_d  = wlo_q;
          we_d   = wr_q;
        end else if (wr_q) begin
          rv_d = 1'b1;
        end
      end
      S_LO: begin
        if (wr_q) rv_d = 1'b1;
        else      hi_d = ram_data_out;
      end
      S_CAP_LO: begin
        rv_d = 1'b1;
        rd_d = {wd_q ? hi_q : 8'h00,
                ram_data_out};
      end
      default: ;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q  <= 4'h0;
      pair_q <= 3'h0;
      wr_q   <= 1'b0;
      wd_q   <= 1'b0;
      wlo_q  <= 8'h00;
      hi_q   <= 8'h00;
      cnt_q  <= 8'h00;
      rv_q   <= 1'b0;
      rd_q   <= 16'h0000;
      we_q   <= 1'b0;
      addr_q <= 8'h00;
      din_q  <= 8'h00;
    end else begin
      lvl_q  <= lvl_d;
      pair_q <= pair_d;
      wr_q   <= wr_d;
      wd_q   <= wd_d;
      wlo_q  <= wlo_d;
      hi_q   <= hi_d;
      cnt_q  <= cnt_d;
      rv_q   <= rv_d;
      rd_q   <= rd_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

endmodule

// File: tb/tb_register_pair_sequencer.sv
// Randomized self-checking bench for register_pair_sequencer
// with a behavioural 256x8 RAM and request-level model.
module tb_register_pair_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  register_pair_sequencer_if bus();

  logic       ram_write_en;
  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  register_pair_sequencer #(.CLEAR_ON_RESET(1'b1)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .ram_write_en (ram_write_en),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  logic [7:0] ram [256];
  logic       fill = 1'b0;

  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'hA5;
    end else if (ram_write_en) begin
      ram[ram_address] <= ram_data_in;
    end
    ram_data_out <= ram[ram_address];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          e0;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [256];
  logic [15:0] mdl_last = 16'h0000;
  logic [15:0] last_seen = 16'h0000;
  int          last_lat = 0;
  int          last_e0 = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // per-cycle response comparison against the model queue
  initial forever begin
    bit exp_v;
    @(negedge clock);
    #1;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    chk("rsp_valid", {31'd0, bus.rsp_valid},
        {31'd0, exp_v});
    if (exp_v) begin
      chk("rsp_rdata", {16'd0, bus.rsp_rdata},
          {16'd0, q[0].data});
      last_seen = bus.rsp_rdata;
      last_lat  = cyc - q[0].e0;
      void'(q.pop_front());
    end
  end

  bit scrub_mon = 1'b0;
  int scrub_exp = 0;
  int scrub_writes = 0;
  int scrub_bad = 0;

  initial forever begin
    @(negedge clock);
    #1;
    if (scrub_mon && ram_write_en) begin
      if (ram_address != scrub_exp[7:0] ||
          ram_data_in != 8'h00)
        scrub_bad++;
      scrub_exp++;
      scrub_writes++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input bit w, input bit wd,
                        input logic [3:0] lv,
                        input logic [3:0] ix,
                        input logic [15:0] wdat,
                        input bit with_clear,
                        output int lowcnt);
    logic [7:0] a;
    int lat;
    int n;
    logic [15:0] d;
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_word    = wd;
    bus.req_level   = lv;
    bus.req_index   = ix;
    bus.req_wdata   = wdat;
    bus.clear_start = with_clear;
    lowcnt = 0;
    if (with_clear) begin
      @(negedge clock);
      bus.clear_start = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    end
    n = 0;
    while (!bus.req_ready && n < 2000) begin
      lowcnt++;
      n++;
      @(negedge clock);
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      a = wd ? {lv, ix[3:1], 1'b0} : {lv, ix};
      if (w) begin
        if (wd) begin
          ref_mem[a]        = wdat[15:8];
          ref_mem[a | 8'd1] = wdat[7:0];
        end else begin
          ref_mem[a] = wdat[7:0];
        end
        d   = mdl_last;
        lat = wd ? 2 : 1;
      end else begin
        d = wd ? {ref_mem[a], ref_mem[a | 8'd1]}
               : {8'h00, ref_mem[a]};
        mdl_last = d;
        lat = wd ? 3 : 2;
      end
      last_e0 = cyc + 1;
      q.push_back('{due: last_e0 + lat,
                    e0: last_e0, data: d});
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("rsp_drain", q.size(), 0);
    @(negedge clock);
  endtask

  task automatic chk_out_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.req_ready}, 0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 0);
    chk({tag, "_rsp_rdata"}, {16'd0, bus.rsp_rdata}, 0);
    chk({tag, "_ram_we"}, {31'd0, ram_write_en}, 0);
    chk({tag, "_ram_addr"}, {24'd0, ram_address}, 0);
    chk({tag, "_ram_din"}, {24'd0, ram_data_in}, 0);
  endtask

  initial begin
    int lc;
    int nz;
    int w_e0;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_word    = 1'b0;
    bus.req_level   = 4'h0;
    bus.req_index   = 4'h0;
    bus.req_wdata   = 16'h0000;
    bus.clear_start = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    @(negedge clock);
    fill = 1'b1;
    @(negedge clock);
    fill = 1'b0;
    repeat (2) @(negedge clock);
    chk_out_zero("reset");

    scrub_mon = 1'b1;
    reset_n = 1'b1;
    lc = 0;
    while (!bus.req_ready && lc < 2000) begin
      lc++;
      @(negedge clock);
    end
    chk("poweron_scrub_len", lc, 256);
    repeat (3) @(negedge clock);
    scrub_mon = 1'b0;
    chk("scrub_writes", scrub_writes, 256);
    chk("scrub_order", scrub_bad, 0);
    nz = 0;
    for (int i = 0; i < 256; i++)
      if (ram[i] !== 8'h00) nz++;
    chk("scrub_all_zero", nz, 0);

    do_req(1, 1, 4'd3, 4'd4, 16'hBEEF, 0, lc);
    wait_idle();
    chk("ww_ram34", {24'd0, ram[8'h34]}, 32'hBE);
    chk("ww_ram35", {24'd0, ram[8'h35]}, 32'hEF);
    chk("ww_latency", last_lat, 2);

    do_req(0, 1, 4'd3, 4'd5, 16'h0000, 0, lc);
    wait_idle();
    chk("wr_data", {16'd0, last_seen}, 32'hBEEF);
    chk("wr_latency", last_lat, 3);

    do_req(0, 0, 4'd3, 4'd5, 16'h0000, 0, lc);
    wait_idle();
    chk("br_data", {16'd0, last_seen}, 32'h00EF);
    chk("br_latency", last_lat, 2);

    do_req(1, 0, 4'd0, 4'd0, 16'hFF5A, 0, lc);
    wait_idle();
    chk("bw_ram00", {24'd0, ram[8'h00]}, 32'h5A);
    chk("bw_ram01", {24'd0, ram[8'h01]}, 32'h00);
    chk("bw_latency", last_lat, 1);
    chk("bw_keeps_rdata", {16'd0, last_seen}, 32'h00EF);

    do_req(1, 1, 4'd15, 4'd14, 16'h1234, 0, lc);
    w_e0 = last_e0;
    do_req(0, 1, 4'd15, 4'd14, 16'h0000, 0, lc);
    chk("b2b_no_gap", last_e0 - w_e0, 3);
    wait_idle();
    chk("b2b_data", {16'd0, last_seen}, 32'h1234);

    do_req(0, 1, 4'd3, 4'd4, 16'h0000, 1, lc);
    chk("req_scrub_len", lc, 256);
    wait_idle();
    chk("read_after_scrub", {16'd0, last_seen}, 0);

    do_req(1, 0, 4'd2, 4'd1, 16'h0055, 0, lc);
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_word  = 1'b1;
    bus.req_level = 4'd2;
    bus.req_index = 4'd0;
    bus.req_wdata = 16'hC33C;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_out_zero("abort");
    chk("abort_ram20", {24'd0, ram[8'h20]}, 32'hC3);
    chk("abort_ram21", {24'd0, ram[8'h21]}, 32'h55);
    mdl_last = 16'h0000;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    lc = 0;
    while (!bus.req_ready && lc < 2000) begin
      lc++;
      @(negedge clock);
    end
    chk("abort_rescrub_len", lc, 256);
    repeat (2) @(negedge clock);

    for (int k = 0; k < 300; k++) begin
      do_req(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)),
             16'($urandom), 0, lc);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    wait_idle();
    nz = 0;
    for (int i = 0; i < 256; i++)
      if (ram[i] !== ref_mem[i]) nz++;
    chk("final_ram_image", nz, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
